finite_mod_unshift: RTL and testbench
=====================================

# finite_mod_unshift

Streaming decoder for the finite-residue offset encoding. The encoder side maps a value to `(x mod MODULUS + OFFSET) mod MODULUS`. This block is the receiving end. It accepts tagged 5-bit residue codes over a valid/ready handshake and rejects codes outside `[0, MODULUS)`. It recovers `(code - OFFSET) mod MODULUS` and buffers results in a 2-entry output queue toward the consumer. It sits directly downstream of the encoder in the finite-arithmetic regression harness.

## Interface
Parameters:
- `MODULUS`, default 20: residue modulus; legal range 2..32.
- `OFFSET`, default 6: additive offset applied by the encoder; legal range 0..MODULUS-1.
- `W`, default 5: code and data width; must satisfy `2^W >= MODULUS`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: producer holds a code.
- `in_ready`, output, 1: block can accept a code this cycle.
- `in_code`, input, W: encoded residue.
- `out_valid`, output, 1: queue head is valid.
- `out_ready`, input, 1: consumer accepts the queue head.
- `out_data`, output, W: decoded residue; 0 when `out_err` is 1.
- `out_err`, output, 1: the head entry came from an illegal code (`>= MODULUS`).
- `err_count`, output, 8: saturating count of illegal codes accepted.
- `checksum`, output, W: running mod-MODULUS sum. Present only with `FINITE_MOD_CHECKSUM_EN`.

## Operation
- **Push:** occurs when `in_valid && in_ready`.
- **Pop:** occurs when `out_valid && out_ready`.
- **Decode (combinational on `in_code`, registered into the queue on push):**
  - `in_code >= MODULUS`: entry is err=1, data=0.
  - `in_code >= OFFSET`: data = `in_code - OFFSET`.
  - Otherwise: data = `in_code + MODULUS - OFFSET`.
  - Intermediate arithmetic is W+1 bits wide; the result is always `< MODULUS`.
- **Queue FSM** (the state is the entry count):
  - EMPTY: push goes to ONE.
  - ONE:
    - push only goes to FULL.
    - pop only goes to EMPTY.
    - push and pop together stay in ONE; the new entry becomes head after the old head leaves.
  - FULL: pop goes to ONE. A push cannot occur here.
- **Port values by state:**
  - `in_ready` = 1 in EMPTY and ONE, 0 in FULL, 0 while `rst` is low. It depends only on state, not on `out_ready`.
  - `out_valid` = 1 in ONE and FULL.
  - `out_data` and `out_err` reflect the head entry, which is ordered FIFO.
- **`err_count`:** increments by 1 on each push of an illegal code. It holds at 255.
- **Head stability:** while `out_valid && !out_ready`, `out_data` and `out_err` hold stable.

## Timing
- **Latency:** a code pushed at edge N appears at `out_valid`/`out_data` after edge N, provided the queue was empty. Minimum latency is 1 cycle.
- **Throughput:** 1 code/cycle is sustained while `out_ready` is held high.
- **Reset** (asynchronous assert, released synchronously with `clk`). All of the following take effect immediately:
  - state goes to EMPTY.
  - `out_valid`=0, `out_data`=0, `out_err`=0.
  - `err_count`=0, `checksum`=0.
  - `in_ready`=0.
  - Reset mid-operation discards all queued entries. No partial pop is produced.
- **Boundary cases:**
  - In FULL, `in_valid` is ignored until a pop.
  - In EMPTY, `out_ready` has no effect.
  - When `err_count` is at 255 and an illegal code is pushed, the count stays at 255.

## Configuration
- `FINITE_MOD_CHECKSUM_EN` defined:
  - The `checksum` port and register exist.
  - On each pop with `out_err`=0, `checksum <= (checksum + out_data) mod MODULUS`.
  - Pops with `out_err`=1 leave it unchanged.
- `FINITE_MOD_CHECKSUM_EN` undefined: no `checksum` port or logic. All other behaviour is identical.

## Test plan
- **Legal decode:** after reset, push codes 12, 3, 19 with `out_ready`=1.
  - Outputs are 6, 17, 13, one per cycle, each 1 cycle after its push.
  - `out_err`=0 and `err_count`=0 throughout.
- **Illegal code:** push 25, then 20.
  - Two entries appear, each with `out_err`=1 and `out_data`=0.
  - `err_count` reads 1, then 2.
  - A following push of 6 yields 0.
- **Backpressure:** with `out_ready`=0, hold `in_valid`=1 for 4 cycles with codes 7, 8, 9, 10.
  - Only 7 and 8 are accepted, and `in_ready`=0 from the second post-push cycle.
  - Raising `out_ready` yields 1 then 2; code 9 is then accepted and yields 3.
- **Simultaneous push/pop in ONE:** queue holds 1 entry, then push and pop occur in the same cycle.
  - State stays ONE and order is preserved.
  - Drive code sequence 0, 5, 11 -> 14, 19, 5.
- **Reset mid-operation:** with the queue FULL and `err_count`=3, pulse `rst` low asynchronously between edges.
  - `out_valid`, `err_count`, `in_ready` clear immediately.
  - After release `in_ready`=1 and no stale data emerges.
- **Checksum (`FINITE_MOD_CHECKSUM_EN` defined):** push 12, 3, 25, 19 and pop all four.
  - `checksum` reads 16 (6+17+13 = 36 mod 20); the error entry is excluded.
  - `err_count`=1.

Source files
------------

// File: rtl/finite_mod_unshift.sv
// finite_mod_unshift: streaming decoder for the finite-residue offset code.
// Accepts W-bit codes, flags codes >= MODULUS as errors, recovers
// (code - OFFSET) mod MODULUS and holds results in a 2-entry FIFO.
// Optional feature macro: FINITE_MOD_CHECKSUM_EN adds a running
// mod-MODULUS sum of every error-free entry popped by the consumer.
module finite_mod_unshift #(
    parameter int MODULUS = 20,
    parameter int OFFSET  = 6,
    parameter int W       = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic [7:0]   err_count
`ifdef FINITE_MOD_CHECKSUM_EN
    ,
    output logic [W-1:0] checksum
`endif
);

    // One extra bit keeps code + MODULUS - OFFSET from wrapping.
    localparam logic [W:0] MOD_X = MODULUS[W:0];
    localparam logic [W:0] OFF_X = OFFSET[W:0];

    // The state is the number of queued entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   head_data_q, head_data_d;
    logic           head_err_q, head_err_d;
    logic [W-1:0]   tail_data_q, tail_data_d;
    logic           tail_err_q, tail_err_d;
    logic [7:0]     err_count_q, err_count_d;

    logic [W:0]     code_x;
    logic           dec_err;
    logic [W-1:0]   dec_data;
    logic           push;
    logic           pop;

    // Decode the incoming code; illegal codes carry data 0.
    always_comb begin
        code_x   = {1'b0, in_code};
        dec_err  = 1'b0;
        dec_data = '0;
        if (code_x >= MOD_X) begin
            dec_err  = 1'b1;
        end else if (code_x >= OFF_X) begin
            dec_data = W'(code_x - OFF_X);
        end else begin
            dec_data = W'(code_x + MOD_X - OFF_X);
        end
    end

    // Ready is a pure function of occupancy, forced low while in reset.
    assign in_ready  = rst && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_err   = head_err_q;
    assign err_count = err_count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Queue next-state: the head is always the oldest entry.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_data_d = dec_data;
                    head_err_d  = dec_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    // Old head leaves as the new entry takes its place.
                    head_data_d = dec_data;
                    head_err_d  = dec_err;
                end else if (push) begin
                    tail_data_d = dec_data;
                    tail_err_d  = dec_err;
                    state_d     = ST_FULL;
                end else if (pop) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Saturating count of accepted illegal codes.
    always_comb begin
        err_count_d = err_count_q;
        if (push && dec_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef FINITE_MOD_CHECKSUM_EN
    logic [W-1:0] checksum_q, checksum_d;
    logic [W:0]   sum_x;

    // Both operands are below MODULUS, so one conditional subtract suffices.
    always_comb begin
        checksum_d = checksum_q;
        sum_x      = {1'b0, checksum_q} + {1'b0, head_data_q};
        if (pop && !head_err_q) begin
            if (sum_x >= MOD_X) begin
                checksum_d = W'(sum_x - MOD_X);
            end else begin
                checksum_d = W'(sum_x);
            end
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_finite_mod_unshift.sv
// Bench for finite_mod_unshift: queue-level reference model checked every
// cycle, plus literal expected pop values for each directed scenario.
module tb_finite_mod_unshift;

    localparam int MOD = 20;
    localparam int OFF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       out_err;
    logic [7:0] err_count;
`ifdef FINITE_MOD_CHECKSUM_EN
    logic [4:0] checksum;
`endif

    finite_mod_unshift #(.MODULUS(MOD), .OFFSET(OFF), .W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_count (err_count)
`ifdef FINITE_MOD_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of decoded entries.
    int m_data[$];
    bit m_err[$];
    int m_errcnt = 0;
    int m_sum = 0;

    // Literal expected pop sequence for the current scenario.
    int e_data[$];
    bit e_err[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_pop(input int d, input bit e);
        e_data.push_back(d);
        e_err.push_back(e);
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the edge.
    task automatic step(input bit v, input logic [4:0] c, input bit r);
        in_valid  = v;
        in_code   = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Model update at each edge from the rules of the queue.
    always @(posedge clk) begin
        if (rst) begin
            bit do_pop;
            bit do_push;
            do_pop  = (m_data.size() > 0) && out_ready;
            do_push = in_valid && (m_data.size() < 2);
            if (do_pop) begin
                if (!m_err[0]) m_sum = (m_sum + m_data[0]) % MOD;
                void'(m_data.pop_front());
                void'(m_err.pop_front());
            end
            if (do_push) begin
                int c;
                c = int'(in_code);
                if (c >= MOD) begin
                    m_data.push_back(0);
                    m_err.push_back(1'b1);
                    if (m_errcnt < 255) m_errcnt++;
                end else begin
                    m_data.push_back((c - OFF + MOD) % MOD);
                    m_err.push_back(1'b0);
                end
            end
        end
    end

    // Reset empties the model immediately.
    always @(negedge rst) begin
        m_data.delete();
        m_err.delete();
        m_errcnt = 0;
        m_sum = 0;
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", int'(out_valid), int'(m_data.size() > 0));
            chk("in_ready", int'(in_ready), int'(m_data.size() < 2));
            chk("err_count", int'(err_count), m_errcnt);
`ifdef FINITE_MOD_CHECKSUM_EN
            chk("checksum", int'(checksum), m_sum);
`endif
            if (m_data.size() > 0) begin
                chk("out_data", int'(out_data), m_data[0]);
                chk("out_err", int'(out_err), int'(m_err[0]));
                if (out_ready) begin
                    $display("pop data=%0d err=%0d err_count=%0d", out_data, out_err, err_count);
                    if (e_data.size() == 0) begin
                        chk("lit_pop_unexpected", 1, 0);
                    end else begin
                        chk("lit_data", int'(out_data), e_data[0]);
                        chk("lit_err", int'(out_err), int'(e_err[0]));
                        void'(e_data.pop_front());
                        void'(e_err.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_code = '0;
        out_ready = 1'b0;
        #12;
        // Reset state.
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        do_reset();

        // Legal decode.
        expect_pop(6, 0); expect_pop(17, 0); expect_pop(13, 0);
        step(1, 5'd12, 1);
        chk("legal_first", int'(out_data), 6);
        step(1, 5'd3, 1);
        step(1, 5'd19, 1);
        step(0, 5'd0, 1);
        chk("legal_errcnt", int'(err_count), 0);
        chk("legal_drained", e_data.size(), 0);

        // Illegal codes.
        expect_pop(0, 1); expect_pop(0, 1); expect_pop(0, 0);
        step(1, 5'd25, 1);
        chk("illegal_cnt1", int'(err_count), 1);
        step(1, 5'd20, 1);
        chk("illegal_cnt2", int'(err_count), 2);
        step(1, 5'd6, 1);
        step(0, 5'd0, 1);
        chk("illegal_drained", e_data.size(), 0);

        // Backpressure.
        expect_pop(1, 0); expect_pop(2, 0); expect_pop(3, 0);
        step(1, 5'd7, 0);
        chk("bp_ready_one", int'(in_ready), 1);
        step(1, 5'd8, 0);
        chk("bp_ready_full", int'(in_ready), 0);
        step(1, 5'd9, 0);
        step(1, 5'd10, 0);
        chk("bp_hold_data", int'(out_data), 1);
        step(1, 5'd9, 1);
        step(1, 5'd9, 1);
        step(0, 5'd0, 1);
        step(0, 5'd0, 1);
        chk("bp_drained", e_data.size(), 0);

        // Simultaneous push/pop in ONE.
        expect_pop(14, 0); expect_pop(19, 0); expect_pop(5, 0);
        step(1, 5'd0, 0);
        step(1, 5'd5, 1);
        chk("pp_valid", int'(out_valid), 1);
        chk("pp_ready", int'(in_ready), 1);
        step(1, 5'd11, 1);
        chk("pp_head", int'(out_data), 5);
        step(0, 5'd0, 1);
        step(0, 5'd0, 0);
        chk("pp_drained", e_data.size(), 0);

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++) expect_pop(0, 1);
        for (int i = 0; i < 256; i++) step(1, 5'd31, 1);
        step(0, 5'd0, 1);
        chk("sat_errcnt", int'(err_count), 255);
        chk("sat_drained", e_data.size(), 0);

        // Reset mid-operation with a full queue and err_count 3.
        do_reset();
        expect_pop(0, 1);
        step(1, 5'd30, 1);
        step(0, 5'd0, 1);
        step(1, 5'd25, 0);
        step(1, 5'd26, 0);
        chk("mid_pre_cnt", int'(err_count), 3);
        chk("mid_pre_valid", int'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_valid", int'(out_valid), 0);
        chk("mid_errcnt", int'(err_count), 0);
        chk("mid_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rel_ready", int'(in_ready), 1);
        step(0, 5'd0, 1);
        step(0, 5'd0, 1);
        expect_pop(18, 0);
        step(1, 5'd4, 1);
        step(0, 5'd0, 1);
        chk("mid_drained", e_data.size(), 0);

        // Checksum scenario.
        do_reset();
        expect_pop(6, 0); expect_pop(17, 0); expect_pop(0, 1); expect_pop(13, 0);
        step(1, 5'd12, 1);
        step(1, 5'd3, 1);
        step(1, 5'd25, 1);
        step(1, 5'd19, 1);
        step(0, 5'd0, 1);
        step(0, 5'd0, 1);
        chk("cs_errcnt", int'(err_count), 1);
`ifdef FINITE_MOD_CHECKSUM_EN
        chk("cs_value", int'(checksum), 16);
`endif
        chk("cs_drained", e_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
